chan_512_fir_coef_loader: RTL and testbench
===========================================

# chan_512_fir_coef_loader

Consumes the 32-bit coefficient word that software writes through the OPB software register for a FIR tap pair (for example b18/b19) in the 512-channel channelizer. It splits the word into two signed 16-bit taps and holds each candidate value in a shadow register until it has been stable for a programmable number of cycles. It then commits both taps together on the next channelizer frame sync, so the FIR never filters a frame with a torn or half-written coefficient pair. The block sits between the register's `user_data_out` and the FIR tap inputs, entirely in the `user_clk` domain.

## Interface
- `STABLE_CYCLES`, default 4: consecutive cycles with an unchanged word required before capture. Legal range 1..255.
- `RESET_COEF`, default 32'h0000_0000: committed word after reset.
- `user_clk` in 1: the single clock.
- `user_rst_n` in 1: asynchronous, active-low reset.
- `reg_data` in 32: coefficient word from the software register. [31:16] = tap A (b18), [15:0] = tap B (b19).
- `sync_in` in 1: one-cycle frame-start pulse from the channelizer.
- `coef_a` out 16: committed tap A, two's complement.
- `coef_b` out 16: committed tap B, two's complement.
- `update_pulse` out 1: high for exactly one cycle, in the first cycle that new `coef_a`/`coef_b` are visible.
- `pending` out 1: high while in SETTLE or ARMED.
- `update_count` out 16: number of commits; wraps from 0xFFFF to 0.

## Operation
- Internal registers:
  - `reg_q`: `reg_data` delayed by one cycle.
  - `active`: the committed 32-bit word. `coef_a` = `active[31:16]`, `coef_b` = `active[15:0]`.
  - `shadow`: 32-bit candidate word.
  - `cnt`: 8-bit stability counter.
- States: IDLE, SETTLE, ARMED.
- IDLE:
  - If `reg_data != active`: go to SETTLE, `cnt` <= 0.
  - Otherwise stay in IDLE.
  - `sync_in` is ignored.
- SETTLE:
  - If `reg_data != reg_q`: `cnt` <= 0.
  - Otherwise `cnt` <= `cnt` + 1.
  - When `reg_data == reg_q` and `cnt == STABLE_CYCLES-1`: `shadow` <= `reg_data`, go to ARMED.
  - If `reg_data == active` and `reg_data == reg_q` (software restored the old value): go to IDLE without a commit.
  - `sync_in` is ignored.
- ARMED:
  - On `sync_in`: `active` <= `shadow`, `update_pulse` <= 1, `update_count` += 1.
    - If `reg_data == shadow`: go to IDLE.
    - If `reg_data != shadow`: go to SETTLE with `cnt` <= 0. The stable shadow is still committed; the newer value then settles.
  - If `reg_data != shadow` and no `sync_in`: discard `shadow`, go to SETTLE with `cnt` <= 0.
- Reset, applied asynchronously at any point including mid-settle or while ARMED:
  - `active` = `RESET_COEF`, `shadow` = `RESET_COEF`, `reg_q` = 0, `cnt` = 0.
  - State = IDLE, `update_pulse` = 0, `pending` = 0, `update_count` = 0.
  - Any pending word is lost. After reset it is re-detected from `reg_data` against `active`.
- Arithmetic: taps are passed through bit-exact with no sign extension or scaling.

## Timing
- Let `reg_data` change before edge 0 and then hold.
  - Edge 0: IDLE to SETTLE.
  - First edge with `reg_data == reg_q`: edge 1.
  - Capture into ARMED: edge `STABLE_CYCLES`.
- Commit: if `sync_in` is sampled high in ARMED at edge k, `coef_a`/`coef_b`/`update_pulse`/`update_count` change at edge k+1's output, i.e. one register stage after the sync edge.
- Minimum latency from change to commit is `STABLE_CYCLES`+2 cycles when sync arrives immediately.
- `sync_in` on consecutive cycles: at most one commit per armed word.
- `pending` is combinational from the state register, with no extra latency.
- All outputs are registered except `pending`.

## Structure
- Package `chan_512_coef_pkg` holds:
  - the state enum (IDLE/SETTLE/ARMED),
  - `COEF_W` = 16 and `WORD_W` = 32,
  - tap field slice constants (`TAP_A_MSB`=31, `TAP_A_LSB`=16, `TAP_B_MSB`=15, `TAP_B_LSB`=0).
- One sub-module, `chan_512_word_stable_detect`:
  - owns `reg_q` and `cnt`,
  - parameter `STABLE_CYCLES`,
  - outputs `stable` (one-cycle strobe) and `changed`.
- The top module holds the FSM, `shadow`, `active` and the counter.

## Test plan
- **Reset:** `RESET_COEF`=32'h0001_FFFF, `reg_data` held at the same value -> `coef_a`=0x0001, `coef_b`=0xFFFF, no `update_pulse` over 100 cycles, `pending`=0.
- **Basic commit:** `STABLE_CYCLES`=4, `reg_data`=32'h1234_8765, `sync_in` at cycle 20 -> `pending` rises at cycle 1, `coef_a`=0x1234 and `coef_b`=0x8765 at cycle 21, one-cycle `update_pulse`, `update_count`=1.
- **Glitch rejection:** `reg_data` toggles between 0xAAAA_0000 and 0x5555_0000 every 2 cycles while `sync_in` pulses every 8 cycles -> no commit. Then hold 0x5555_0000 -> commit at the first sync after 4 stable cycles.
- **Change while ARMED:**
  - Arm 0x0000_0010, then write 0x0000_0020 on the same cycle as `sync_in` -> 0x0000_0010 committed, SETTLE entered, 0x0000_0020 committed at the next sync. `update_count`=2.
  - Same sequence but with the change one cycle before sync -> only 0x0000_0020 is ever committed.
- **Reset mid-operation:** assert `user_rst_n` low while ARMED with 0xDEAD_BEEF -> outputs return to `RESET_COEF` immediately. After release with `reg_data` still 0xDEAD_BEEF, the word re-settles and commits at the next sync.
- **Counter wrap:** preload the sequence to 65535 commits (or force `update_count`=0xFFFF) plus one more commit -> `update_count`=0x0000.

Source files
------------

// File: rtl/chan_512_coef_pkg.sv
// rtl/chan_512_coef_pkg.sv - shared types and field constants for the FIR coefficient loader
package chan_512_coef_pkg;

  localparam int COEF_W    = 16;
  localparam int WORD_W    = 32;
  localparam int TAP_A_MSB = 31;
  localparam int TAP_A_LSB = 16;
  localparam int TAP_B_MSB = 15;
  localparam int TAP_B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ARMED  = 2'd2
  } coef_state_e;

endpackage

// File: rtl/chan_512_word_stable_detect.sv
// rtl/chan_512_word_stable_detect.sv - flags when a word has held still for STABLE_CYCLES cycles
module chan_512_word_stable_detect
  import chan_512_coef_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] data,
  input  logic              run,
  output logic              stable,
  output logic              changed
);

  localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

  logic [WORD_W-1:0] reg_q;
  logic [7:0]        cnt;

  assign changed = (data != reg_q);
  assign stable  = run && !changed && (cnt == LAST_CNT);

  // The counter only advances while the owner is settling; any other state parks it at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= '0;
      cnt   <= '0;
    end else begin
      reg_q <= data;
      if (!run || changed) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/chan_512_fir_coef_loader.sv
// rtl/chan_512_fir_coef_loader.sv - debounces a software tap-pair word and commits it on frame sync
module chan_512_fir_coef_loader
  import chan_512_coef_pkg::*;
#(
  parameter int                STABLE_CYCLES = 4,
  parameter logic [WORD_W-1:0] RESET_COEF    = 32'h0000_0000
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [WORD_W-1:0] reg_data,
  input  logic              sync_in,
  output logic [COEF_W-1:0] coef_a,
  output logic [COEF_W-1:0] coef_b,
  output logic              update_pulse,
  output logic              pending,
  output logic [15:0]       update_count
);

  coef_state_e       state;
  coef_state_e       state_next;
  logic [WORD_W-1:0] shadow;
  logic [WORD_W-1:0] active;
  logic              run;
  logic              stable;
  logic              changed;
  logic              capture;
  logic              commit;

  assign run = (state == SETTLE);

  chan_512_word_stable_detect #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stable (
    .clk     (user_clk),
    .rst_n   (user_rst_n),
    .data    (reg_data),
    .run     (run),
    .stable  (stable),
    .changed (changed)
  );

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (reg_data != active) state_next = SETTLE;
      end
      SETTLE: begin
        // A restore of the committed word wins over capture so nothing redundant is committed.
        if (!changed && (reg_data == active)) begin
          state_next = IDLE;
        end else if (stable) begin
          capture    = 1'b1;
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (sync_in) begin
          commit     = 1'b1;
          state_next = (reg_data == shadow) ? IDLE : SETTLE;
        end else if (reg_data != shadow) begin
          state_next = SETTLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state        <= IDLE;
      shadow       <= RESET_COEF;
      active       <= RESET_COEF;
      update_pulse <= 1'b0;
      update_count <= '0;
    end else begin
      state        <= state_next;
      update_pulse <= commit;
      if (capture) shadow <= reg_data;
      if (commit) begin
        active       <= shadow;
        update_count <= update_count + 16'd1;
      end
    end
  end

  assign coef_a  = active[TAP_A_MSB:TAP_A_LSB];
  assign coef_b  = active[TAP_B_MSB:TAP_B_LSB];
  assign pending = (state != IDLE);

endmodule

// File: tb/tb_chan_512_fir_coef_loader.sv
// tb/tb_chan_512_fir_coef_loader.sv - directed self-checking bench for the coefficient loader
module tb_chan_512_fir_coef_loader;

  logic        clk;
  logic        rst_n;
  logic [31:0] reg_data;
  logic        sync_in;
  logic [15:0] coef_a;
  logic [15:0] coef_b;
  logic        update_pulse;
  logic        pending;
  logic [15:0] update_count;

  int checks;
  int errors;
  int pulses;

  chan_512_fir_coef_loader #(
    .STABLE_CYCLES(4),
    .RESET_COEF   (32'h0001_FFFF)
  ) dut (
    .user_clk    (clk),
    .user_rst_n  (rst_n),
    .reg_data    (reg_data),
    .sync_in     (sync_in),
    .coef_a      (coef_a),
    .coef_b      (coef_b),
    .update_pulse(update_pulse),
    .pending     (pending),
    .update_count(update_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_once();
    sync_in = 1'b1;
    step(1);
    sync_in = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    sync_in  = 1'b0;
    reg_data = 32'h0001_FFFF;
    step(2);
    check("rst_coef_a", {16'h0, coef_a}, 32'h0001);
    check("rst_coef_b", {16'h0, coef_b}, 32'hFFFF);
    check("rst_count", {16'h0, update_count}, 32'h0);
    rst_n = 1'b1;

    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (update_pulse || pending) pulses++;
    end
    check("rst_quiet_100", pulses, 0);

    // Basic commit: change before edge 0, sync sampled at edge 20.
    reg_data = 32'h1234_8765;
    step(1);
    check("basic_pending_rise", {31'h0, pending}, 32'h1);
    step(2);
    sync_once();
    check("basic_sync_ignored_settle", {31'h0, update_pulse}, 32'h0);
    check("basic_coef_a_hold", {16'h0, coef_a}, 32'h0001);
    step(16);
    check("basic_armed_pending", {31'h0, pending}, 32'h1);
    sync_once();
    check("basic_coef_a", {16'h0, coef_a}, 32'h1234);
    check("basic_coef_b", {16'h0, coef_b}, 32'h8765);
    check("basic_pulse", {31'h0, update_pulse}, 32'h1);
    check("basic_count", {16'h0, update_count}, 32'h1);
    step(1);
    check("basic_pulse_drop", {31'h0, update_pulse}, 32'h0);
    check("basic_pending_drop", {31'h0, pending}, 32'h0);

    // Glitch rejection: word toggles every 2 cycles, sync every 8.
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      reg_data = ((i / 2) % 2 == 1) ? 32'h5555_0000 : 32'hAAAA_0000;
      sync_in  = (i % 8 == 7);
      step(1);
      if (update_pulse) pulses++;
    end
    sync_in = 1'b0;
    check("glitch_no_commit", pulses, 0);
    check("glitch_coef_a_hold", {16'h0, coef_a}, 32'h1234);
    step(6);
    sync_once();
    check("glitch_settled_coef_a", {16'h0, coef_a}, 32'h5555);
    check("glitch_settled_count", {16'h0, update_count}, 32'h2);

    // Change on the same cycle as sync: armed word commits, new word settles behind it.
    reg_data = 32'h0000_0010;
    step(6);
    reg_data = 32'h0000_0020;
    sync_once();
    check("armchg_first_coef_b", {16'h0, coef_b}, 32'h0010);
    check("armchg_first_pending", {31'h0, pending}, 32'h1);
    check("armchg_first_count", {16'h0, update_count}, 32'h3);
    step(6);
    sync_once();
    check("armchg_second_coef_b", {16'h0, coef_b}, 32'h0020);
    check("armchg_second_count", {16'h0, update_count}, 32'h4);

    // Change one cycle before sync: the armed word is discarded.
    reg_data = 32'h0000_0040;
    step(6);
    reg_data = 32'h0000_0050;
    step(1);
    sync_once();
    check("discard_no_pulse", {31'h0, update_pulse}, 32'h0);
    check("discard_coef_b_hold", {16'h0, coef_b}, 32'h0020);
    step(6);
    sync_once();
    check("discard_new_coef_b", {16'h0, coef_b}, 32'h0050);
    check("discard_count", {16'h0, update_count}, 32'h5);

    // Reset while ARMED, then re-detect with minimum latency.
    reg_data = 32'hDEAD_BEEF;
    step(6);
    check("midrst_armed", {31'h0, pending}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_coef_a", {16'h0, coef_a}, 32'h0001);
    check("midrst_coef_b", {16'h0, coef_b}, 32'hFFFF);
    check("midrst_pending", {31'h0, pending}, 32'h0);
    check("midrst_count", {16'h0, update_count}, 32'h0);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("midrst_resettle", {31'h0, pending}, 32'h1);
    step(4);
    sync_once();
    check("midrst_coef_a_new", {16'h0, coef_a}, 32'hDEAD);
    check("midrst_coef_b_new", {16'h0, coef_b}, 32'hBEEF);
    check("midrst_count_new", {16'h0, update_count}, 32'h1);

    // Counter wrap, plus sync held high: one commit per armed word.
    force dut.update_count = 16'hFFFF;
    step(1);
    release dut.update_count;
    reg_data = 32'h1111_2222;
    step(6);
    sync_in = 1'b1;
    step(1);
    check("wrap_count", {16'h0, update_count}, 32'h0);
    check("wrap_coef_a", {16'h0, coef_a}, 32'h1111);
    check("wrap_pulse", {31'h0, update_pulse}, 32'h1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (update_pulse) pulses++;
    end
    sync_in = 1'b0;
    check("held_sync_single", pulses, 0);
    check("held_sync_count", {16'h0, update_count}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
